quarter_wave_sequencer: RTL
===========================

# quarter_wave_sequencer

Upstream driver for the 128-entry quarter-wave sample memory. Paces sample playback with a programmable clock divider and walks the memory address up and down through four quadrants to produce one 512-sample full period. Drives the memory's `read_address` and `invert_data` inputs. Emits a strobe, plus a matching invert flag, on the cycle the memory's registered output holds the corresponding sample.

## Interface
- `DIV_WIDTH`, default 16: width of the `step_div` divider input.
- `clk` in 1: system clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: high lets the divider run and steps advance; low freezes all state.
- `step_div` in DIV_WIDTH: clock cycles per sample step, minus 1; sampled live.
- `read_address` out 7: memory read address.
- `invert_data` out 1: invert flag for the memory, same cycle as `read_address`.
- `quadrant` out 2: current quadrant, 0–3.
- `sample_strobe` out 1: one-cycle pulse; the memory `data` output is valid for the step just taken.
- `sample_invert` out 1: `invert_data` delayed to align with `sample_strobe`.

## Operation
- **Divider.** `div_cnt` (DIV_WIDTH bits) counts 0..`step_div`.
  - A step occurs in a cycle where `enable`=1 and `div_cnt`==`step_div`; `div_cnt` then returns to 0.
  - Otherwise, if `enable`=1, `div_cnt` increments.
  - If `enable`=0, `div_cnt` holds.
  - If `step_div` is lowered below the current `div_cnt`, a step occurs immediately and `div_cnt` returns to 0. Compare with `>=`, not `==`.
  - `step_div`=0 gives one step every enabled cycle.
- **Quadrant FSM.** States Q0..Q3; `quadrant` is the state encoding.
  - Q0: address ascends 0→127, `invert_data`=0.
  - Q1: address descends 127→0, `invert_data`=0.
  - Q2: address ascends 0→127, `invert_data`=1.
  - Q3: address descends 127→0, `invert_data`=1.
- **Quadrant transitions.** At a quadrant boundary the address does not move; it repeats the endpoint.
  - Q0 at 127 → Q1 at 127.
  - Q1 at 0 → Q2 at 0.
  - Q2 at 127 → Q3 at 127.
  - Q3 at 0 → Q0 at 0.
  - Each quadrant therefore presents 128 samples, and a full period is exactly 512 steps.
- **Outputs.** `invert_data` is 1 exactly when the state is Q2 or Q3. It is registered together with `read_address` and `quadrant`.
- **Strobe pipeline.** A step is delayed through a 2-stage shift register, s1 then s2; `sample_strobe` = s2.
  - `invert_data` is delayed one register so that `sample_invert` changes in the same cycle as `sample_strobe`.
  - The pipeline keeps shifting while `enable`=0, so a strobe already in flight still completes.
- **Reset.** Asynchronous on `rst_n`=0. All of the following clear to 0: `div_cnt`, `read_address`, `quadrant` (Q0), `invert_data`, `sample_strobe`, `sample_invert`, and both pipeline stages.
  - The reset position (Q0, address 0) is not strobed.
  - The first step moves to Q0, address 1.
  - Reset mid-period discards position and any in-flight strobe.

## Timing
- Step detected in cycle N:
  - `read_address`, `invert_data` and `quadrant` update at edge N+1.
  - The memory registers data at edge N+2.
  - `sample_strobe`=1 and `sample_invert` are valid from edge N+2 for exactly one cycle.
- Step period is `step_div`+1 enabled cycles; output period is 512×(`step_div`+1) enabled cycles.
- With `step_div`=0, `sample_strobe` is continuously high after a 2-cycle fill.
- No output changes while `enable`=0, except for completion of in-flight strobes.
- Deasserting `rst_n` takes effect on the next rising edge; the first step can occur at the earliest at the `step_div`+1-th enabled cycle.

## Test plan
- **Reset state.** Hold `rst_n`=0 with `enable`=1 → all outputs are 0. Release with `step_div`=3 → the first step is in the 4th enabled cycle, `read_address`=1 one edge later, and `sample_strobe` pulses one cycle after that.
- **Full period.** `step_div`=0, `enable`=1, run 1024 cycles → address sequence 0..127, 127..0, 0..127, 127..0 repeating. `invert_data`=1 exactly for the middle-to-end 256 of each 512 steps. Endpoints 127 and 0 each appear twice consecutively at boundaries. `quadrant` wraps 3→0.
- **Strobe alignment.** Connect the quarter-wave memory loaded with value = address. At every `sample_strobe`, memory `data[8:0]` equals the address stepped to 2 edges earlier, `data[9]`=1, and `sample_invert` equals that step's `invert_data`.
- **Enable pause.** `step_div`=4; drop `enable` for 10 cycles at `div_cnt`=2 → `read_address` and `div_cnt` hold. After re-enable, the next step occurs 3 enabled cycles later. A strobe launched just before the pause still appears.
- **Divider change.** At `div_cnt`=9 with `step_div`=15, write `step_div`=5 → a step occurs immediately and subsequent steps are every 6 cycles. Then set 0 → a strobe every cycle.
- **Mid-period reset.** Assert `rst_n`=0 asynchronously in Q2 at address 60, between clock edges, with a strobe in flight → outputs clear immediately. No strobe follows, and the sequence restarts from Q0, address 0.

Source files
------------

// File: rtl/quarter_wave_sequencer_if.sv
// Bundle between the quarter-wave sequencer and its controller/consumer.
// The master side is the sequencer: it takes pacing controls and drives
// the memory address, invert flag, quadrant and the aligned sample strobe.
interface quarter_wave_sequencer_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic [DIV_WIDTH-1:0] step_div;
  logic [6:0]           read_address;
  logic                 invert_data;
  logic [1:0]           quadrant;
  logic                 sample_strobe;
  logic                 sample_invert;

  modport master (
    input  enable, step_div,
    output read_address, invert_data, quadrant, sample_strobe, sample_invert
  );

  modport slave (
    output enable, step_div,
    input  read_address, invert_data, quadrant, sample_strobe, sample_invert
  );
endinterface

// File: rtl/quarter_wave_sequencer.sv
// Quarter-wave sequencer: paces steps with a programmable divider and walks
// a 128-entry quarter-wave memory up/down through four quadrants, giving a
// 512-step full period. A 2-stage strobe pipeline marks the cycle on which
// the memory's registered output holds the sample for each step.
module quarter_wave_sequencer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  quarter_wave_sequencer_if.master bus
);

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} state_t;

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_step;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [6:0]           r_addr;
  logic [6:0]           w_addr_nxt;
  logic                 r_vld_p1;
  logic                 r_vld_p2;
  logic                 r_inv_p2;

  // A step fires when the count has reached (or, after step_div was lowered,
  // passed) the programmed terminal value.
  assign w_step = bus.enable && (r_div_cnt >= bus.step_div);

  // Divider: wraps to 0 on a step, counts while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_step) begin
      r_div_cnt <= '0;
    end else if (bus.enable) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // State register: quadrant and address advance together on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q0;
      r_addr  <= '0;
    end else if (w_step) begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next-state: ascend in Q0/Q2, descend in Q1/Q3; at an endpoint the
  // address repeats while the quadrant advances.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      Q0: if (r_addr == 7'd127) w_state_nxt = Q1; else w_addr_nxt = r_addr + 7'd1;
      Q1: if (r_addr == 7'd0)   w_state_nxt = Q2; else w_addr_nxt = r_addr - 7'd1;
      Q2: if (r_addr == 7'd127) w_state_nxt = Q3; else w_addr_nxt = r_addr + 7'd1;
      Q3: if (r_addr == 7'd0)   w_state_nxt = Q0; else w_addr_nxt = r_addr - 7'd1;
      default: begin
        w_state_nxt = Q0;
        w_addr_nxt  = '0;
      end
    endcase
  end

  // Outputs straight from registers; invert is the upper state bit (Q2/Q3),
  // so it is glitch-free and changes with the address.
  always_comb begin
    bus.read_address  = r_addr;
    bus.quadrant      = r_state;
    bus.invert_data   = r_state[1];
    bus.sample_strobe = r_vld_p2;
    bus.sample_invert = r_inv_p2;
  end

  // Strobe pipeline: p1 = address presented, p2 = memory data registered.
  // Keeps shifting regardless of enable so in-flight strobes complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_inv_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_step;
      r_vld_p2 <= r_vld_p1;
      r_inv_p2 <= r_state[1];
    end
  end

endmodule
